ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4: RAM address width (16 locations).
REQ-002 Parameter DATA_W, default 8: RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents a command.
REQ-006 reqN_we  input  1  1 = write, 0 = read.
REQ-007 reqN_addr  input  ADDR_W  command address.
REQ-008 reqN_wdata  input  DATA_W  write data.
REQ-009 reqN_ready  output  1  command of requester N accepted this cycle.
REQ-010 rspN_valid  output  1  one-cycle pulse: read data for requester N valid.
REQ-011 rspN_rdata  output  DATA_W  read data, meaningful only while rspN_valid is high.
REQ-012 clear_start  input  1  pulse: request zero-fill of all locations.
REQ-013 clear_busy  output  1  high while the clear sweep runs.
REQ-014 clear_done  output  1  one-cycle pulse after the last clear write.
REQ-015 ram_we, ram_addr, ram_din  output  1/ADDR_W/DATA_W  drive the sync_ram port.
REQ-016 ram_dout  input  DATA_W  sync_ram read data, valid the cycle after the address is sampled.

Function
REQ-017 The FSM SHALL have exactly two states, SERVE and CLEAR; it leaves reset in SERVE.
REQ-018 In SERVE: at most one grant per cycle; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-019 reqN_ready SHALL be combinational from valid inputs, state and the round-robin pointer, and never high without reqN_valid.
REQ-020 Only one requester valid: it is granted in the same cycle.
REQ-021 Both valid: grant goes to the requester not granted most recently; the pointer updates only on a grant.
REQ-022 Granted command drives ram_we=reqN_we, ram_addr=reqN_addr, ram_din=reqN_wdata in the grant cycle.
REQ-023 Cycle with no grant: ram_we=0.
REQ-024 Granted read: rspN_valid pulses exactly one cycle after the grant; rspN_rdata=ram_dout in that cycle.
REQ-025 Granted write produces no response.
REQ-026 Back-to-back grants SHALL sustain one access per cycle, with no bubble between requesters or between read and write.
REQ-027 A read granted the cycle after a write to the same address SHALL return the newly written data.
REQ-028 Requesters SHALL hold valid, we, addr and wdata stable until ready; no response backpressure exists.
REQ-029 clear_start in SERVE: enter CLEAR next cycle; a grant in the same cycle still completes.
REQ-030 In CLEAR: both ready low; a 4-bit counter sweeps addresses 0..15 with ram_we=1 and ram_din=0, one per cycle; clear_busy=1.
REQ-031 After the address-15 write: return to SERVE, pulse clear_done for one cycle, reset the counter to 0.
REQ-032 clear_start in CLEAR is ignored; a pending read response SHALL still be delivered in the cycle after entering CLEAR.

Reset
REQ-033 rst_n low SHALL immediately force all outputs low: readys, rsp valids, clear_busy, clear_done, ram_we.
REQ-034 rst_n low SHALL set rspN_rdata, ram_addr and ram_din to 0.
REQ-035 rst_n low SHALL set the state to SERVE, the counter to 0, drop any pending response, and set the pointer so requester 0 wins the first contention.
REQ-036 Reset during CLEAR SHALL abort the sweep; memory contents are then unspecified.

Structure
REQ-037 A shared package SHALL hold ADDR_W, DATA_W, NUM_REQ=2 and the SERVE/CLEAR state encoding.
REQ-038 The memory stays in the existing sync_ram module, instantiated beside ram_arbiter at the top level, not inside it.

Verification
REQ-039 After reset: req0 writes 0xA5 to addr 3; req1 reads addr 3 next cycle -> rsp1_valid one cycle later with 0xA5.
REQ-040 Both requesters valid 4 cycles, reading addr 1 and addr 2 -> grant order 0,1,0,1; rsp valids alternate with the correct data.
REQ-041 Fill addr 0..15 with 0xA0+i, then req0 reads all 16 back-to-back -> 16 consecutive responses 0xA0..0xAF.
REQ-042 clear_start during contention -> readys low for 16 cycles, clear_done after addr 15, then all reads return 0x00.
REQ-043 rst_n low mid-CLEAR at addr 7 -> outputs low at once; after release the state is SERVE and req0 is granted first.
REQ-044 Read granted in the clear_start cycle -> its response is still delivered the next cycle.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared constants, FSM encoding and the two-requester round-robin pick
// used by the RAM arbiter and its priority tracker.
package ram_arbiter_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // prio=1 favours requester 1 when both are valid.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic               prio);
    logic [NUM_REQ-1:0] grant;
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio ? 2'b10 : 2'b01;
    end
    return grant;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr.sv
// Round-robin grant for two requesters; priority flips only when a grant
// is issued, so an idle cycle never disturbs fairness.
module ram_arbiter_rr
  import ram_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic prio_q, prio_d;

  assign grant_o = en_i ? rr_pick(valid_i, prio_q) : '0;

  always_comb begin
    prio_d = prio_q;
    if (grant_o[0]) begin
      prio_d = 1'b1;
    end else if (grant_o[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with registered read (read-before-write),
// instantiated next to the arbiter by the enclosing level.
module sync_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester front end for an external sync_ram: round-robin access in
// SERVE, a zero-fill sweep of every location in CLEAR.
module ram_arbiter #(
  parameter int ADDR_W = ram_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ram_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  import ram_arbiter_pkg::NUM_REQ;
  import ram_arbiter_pkg::state_e;
  import ram_arbiter_pkg::SERVE;
  import ram_arbiter_pkg::CLEAR;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               clear_done_q, clear_done_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  req_addr  [NUM_REQ];
  logic [DATA_W-1:0]  req_wdata [NUM_REQ];
  logic [DATA_W-1:0]  rsp_rdata [NUM_REQ];
  logic               serve_en;

  assign req_valid    = {req1_valid, req0_valid};
  assign req_we       = {req1_we, req0_we};
  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;

  // rst_n is folded in so the combinational outputs drop the instant reset asserts.
  assign serve_en = rst_n && (state_q == SERVE);

  ram_arbiter_rr u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (serve_en),
    .valid_i (req_valid),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SERVE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SERVE:   if (clear_start)        state_d = CLEAR;
      CLEAR:   if (cnt_q == LAST_ADDR) state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    clear_busy = 1'b0;
    if (rst_n) begin
      if (state_q == CLEAR) begin
        ram_we     = 1'b1;
        ram_addr   = cnt_q;
        clear_busy = 1'b1;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) begin
            ram_we   = req_we[i];
            ram_addr = req_addr[i];
            ram_din  = req_wdata[i];
          end
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = (cnt_q == LAST_ADDR) ? '0 : cnt_q + 1'b1;
    end
    clear_done_d = (state_q == CLEAR) && (cnt_q == LAST_ADDR);
    rsp_valid_d  = grant & ~req_we;
  end

  // The response flag is kept across the SERVE->CLEAR switch so a read
  // granted alongside clear_start is still answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_rdata[gi] = rsp_valid_q[gi] ? ram_dout : '0;
    end
  endgenerate

  assign clear_done = clear_done_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp1_rdata = rsp_rdata[1];

endmodule
